cc_sevenseg_scan: RTL

- Parametrised N-digit multiplexed seven-segment driver; successor to the fixed 4-digit scanner.
- Adds: configurable digit count and scan rate; double-buffered, tear-free frame updates via load/pending handshake; hex/decimal glyph mode; per-digit decimal point and blanking; leading-zero suppression; PWM brightness.
- Sits between game/score logic and the board display pins.

---
 rtl/cc_sevenseg_pkg.sv | 48 ++++
 rtl/cc_sevenseg_decode.sv | 18 +
 rtl/cc_sevenseg_scan.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cc_sevenseg_pkg.sv
// Shared glyph constants and nibble-to-glyph lookup for the seven-segment scanner.
// Glyphs are stored active-low, bit order {g,f,e,d,c,b,a}.
package cc_sevenseg_pkg;

  localparam logic [6:0] GLYPH_0    = 7'h40;
  localparam logic [6:0] GLYPH_1    = 7'h79;
  localparam logic [6:0] GLYPH_2    = 7'h24;
  localparam logic [6:0] GLYPH_3    = 7'h30;
  localparam logic [6:0] GLYPH_4    = 7'h19;
  localparam logic [6:0] GLYPH_5    = 7'h12;
  localparam logic [6:0] GLYPH_6    = 7'h02;
  localparam logic [6:0] GLYPH_7    = 7'h78;
  localparam logic [6:0] GLYPH_8    = 7'h00;
  localparam logic [6:0] GLYPH_9    = 7'h10;
  localparam logic [6:0] GLYPH_A    = 7'h08;
  localparam logic [6:0] GLYPH_B    = 7'h03;
  localparam logic [6:0] GLYPH_C    = 7'h46;
  localparam logic [6:0] GLYPH_D    = 7'h21;
  localparam logic [6:0] GLYPH_E    = 7'h06;
  localparam logic [6:0] GLYPH_F    = 7'h0E;
  localparam logic [6:0] GLYPH_DASH = 7'b0111111;
  localparam logic [6:0] GLYPH_OFF  = 7'h7F;

  function automatic logic [6:0] glyph(input logic [3:0] nibble, input logic hex_mode);
    logic [6:0] g;
    case (nibble)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    if (!hex_mode && (nibble > 4'd9)) g = GLYPH_DASH;
    return g;
  endfunction

endpackage

// File: rtl/cc_sevenseg_decode.sv
// Combinational nibble decoder: glyph lookup, blanking and segment polarity.
module cc_sevenseg_decode
  import cc_sevenseg_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] i_nibble,
  input  logic       i_hex_mode,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  logic [6:0] w_glyph;

  assign w_glyph = i_blank ? GLYPH_OFF : glyph(i_nibble, i_hex_mode);
  assign o_seg   = SEG_ACTIVE_LOW ? w_glyph : ~w_glyph;

endmodule

// File: rtl/cc_sevenseg_scan.sv
// N-digit multiplexed seven-segment scanner with double-buffered frames, LZS and PWM.
// Optional per-digit blinking is compiled in with CC_SEVENSEG_SCAN_BLINK_EN.
module cc_sevenseg_scan
  import cc_sevenseg_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int SCAN_DIV       = 12500,
  parameter int DUTY_W         = 4,
  parameter bit AN_ACTIVE_HIGH = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
`ifdef CC_SEVENSEG_SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES   = 250
`endif
) (
  input  logic                  CC_SEVENSEG_SCAN_CLOCK_50,
  input  logic                  CC_SEVENSEG_SCAN_RESET_InLow,
  input  logic [4*N_DIGITS-1:0] CC_SEVENSEG_SCAN_data,
  input  logic [N_DIGITS-1:0]   CC_SEVENSEG_SCAN_dp,
  input  logic [N_DIGITS-1:0]   CC_SEVENSEG_SCAN_blank,
`ifdef CC_SEVENSEG_SCAN_BLINK_EN
  input  logic [N_DIGITS-1:0]   CC_SEVENSEG_SCAN_blink,
`endif
  input  logic                  CC_SEVENSEG_SCAN_load,
  input  logic                  CC_SEVENSEG_SCAN_hex_mode,
  input  logic                  CC_SEVENSEG_SCAN_lzs,
  input  logic [DUTY_W-1:0]     CC_SEVENSEG_SCAN_bright,
  output logic [6:0]            CC_SEVENSEG_SCAN_seg,
  output logic                  CC_SEVENSEG_SCAN_dp_out,
  output logic [N_DIGITS-1:0]   CC_SEVENSEG_SCAN_an,
  output logic                  CC_SEVENSEG_SCAN_pending,
  output logic                  CC_SEVENSEG_SCAN_frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int SLICE = SCAN_DIV >> DUTY_W;
  localparam logic [CNT_W-1:0]    SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF    = {N_DIGITS{~AN_ACTIVE_HIGH}};
  localparam logic [6:0]          SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                DP_OFF    = SEG_ACTIVE_LOW;

  logic [CNT_W-1:0]      r_slot_cnt;
  logic [IDX_W-1:0]      r_digit_idx;
  logic [4*N_DIGITS-1:0] r_stg_data, r_sh_data;
  logic [N_DIGITS-1:0]   r_stg_dp, r_sh_dp;
  logic [N_DIGITS-1:0]   r_stg_blank, r_sh_blank;
  logic                  r_pending;
  logic                  r_frame_tick;
  logic [N_DIGITS-1:0]   r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;

  logic                  w_slot_end;
  logic                  w_frame_end;
  logic                  w_transfer;
  logic [31:0]           w_thresh;
  logic                  w_on;
  logic [N_DIGITS-1:0]   w_sup;
  logic                  w_run;
  logic [N_DIGITS-1:0]   w_blink_off;
  logic [N_DIGITS-1:0]   w_eff_blank;
  logic                  w_dig_blank;
  logic [3:0]            w_nibble;
  logic                  w_dp_req;
  logic [N_DIGITS-1:0]   w_onehot;
  logic [6:0]            w_seg;

  assign w_slot_end  = (r_slot_cnt == SLOT_LAST);
  assign w_frame_end = w_slot_end && (r_digit_idx == IDX_LAST);
  // A load on the boundary cycle keeps the new capture staged for one more frame.
  assign w_transfer  = w_frame_end && r_pending && !CC_SEVENSEG_SCAN_load;

  always_ff @(posedge CC_SEVENSEG_SCAN_CLOCK_50 or negedge CC_SEVENSEG_SCAN_RESET_InLow) begin
    if (!CC_SEVENSEG_SCAN_RESET_InLow) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= '0;
    end else if (w_slot_end) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= (r_digit_idx == IDX_LAST) ? '0 : r_digit_idx + IDX_W'(1);
    end else begin
      r_slot_cnt  <= r_slot_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CC_SEVENSEG_SCAN_CLOCK_50 or negedge CC_SEVENSEG_SCAN_RESET_InLow) begin
    if (!CC_SEVENSEG_SCAN_RESET_InLow) begin
      r_stg_data   <= '0;
      r_stg_dp     <= '0;
      r_stg_blank  <= '0;
      r_sh_data    <= '0;
      r_sh_dp      <= '0;
      r_sh_blank   <= '1;
      r_pending    <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_end;
      if (CC_SEVENSEG_SCAN_load) begin
        r_stg_data  <= CC_SEVENSEG_SCAN_data;
        r_stg_dp    <= CC_SEVENSEG_SCAN_dp;
        r_stg_blank <= CC_SEVENSEG_SCAN_blank;
        r_pending   <= 1'b1;
      end else if (w_transfer) begin
        r_pending   <= 1'b0;
      end
      if (w_transfer) begin
        r_sh_data  <= r_stg_data;
        r_sh_dp    <= r_stg_dp;
        r_sh_blank <= r_stg_blank;
      end
    end
  end

`ifdef CC_SEVENSEG_SCAN_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

  logic [N_DIGITS-1:0] r_stg_blink, r_sh_blink;
  logic [BF_W-1:0]     r_blink_cnt;
  logic                r_blink_phase;

  always_ff @(posedge CC_SEVENSEG_SCAN_CLOCK_50 or negedge CC_SEVENSEG_SCAN_RESET_InLow) begin
    if (!CC_SEVENSEG_SCAN_RESET_InLow) begin
      r_stg_blink   <= '0;
      r_sh_blink    <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else begin
      if (CC_SEVENSEG_SCAN_load) r_stg_blink <= CC_SEVENSEG_SCAN_blink;
      if (w_transfer)            r_sh_blink  <= r_stg_blink;
      if (w_frame_end) begin
        if (r_blink_cnt == BF_LAST) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt   <= r_blink_cnt + BF_W'(1);
        end
      end
    end
  end

  assign w_blink_off = r_sh_blink & {N_DIGITS{~r_blink_phase}};
`else
  assign w_blink_off = '0;
`endif

  // Suppression walks down from the most significant digit; digit 0 always shows.
  always_comb begin
    w_run = CC_SEVENSEG_SCAN_lzs;
    w_sup = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      w_run    = w_run && (r_sh_data[4*i +: 4] == 4'h0) && !r_sh_dp[i];
      w_sup[i] = w_run;
    end
  end

  assign w_thresh    = 32'(CC_SEVENSEG_SCAN_bright) * 32'(SLICE);
  assign w_on        = (&CC_SEVENSEG_SCAN_bright) || (32'(r_slot_cnt) < w_thresh);
  assign w_eff_blank = r_sh_blank | w_sup | w_blink_off;
  assign w_dig_blank = w_eff_blank[r_digit_idx];
  assign w_nibble    = r_sh_data[{r_digit_idx, 2'b00} +: 4];
  assign w_dp_req    = r_sh_dp[r_digit_idx];
  assign w_onehot    = {{(N_DIGITS-1){1'b0}}, 1'b1} << r_digit_idx;

  cc_sevenseg_decode #(
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_decode (
    .i_nibble   (w_nibble),
    .i_hex_mode (CC_SEVENSEG_SCAN_hex_mode),
    .i_blank    (w_dig_blank || !w_on),
    .o_seg      (w_seg)
  );

  always_ff @(posedge CC_SEVENSEG_SCAN_CLOCK_50 or negedge CC_SEVENSEG_SCAN_RESET_InLow) begin
    if (!CC_SEVENSEG_SCAN_RESET_InLow) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= DP_OFF;
    end else begin
      r_an  <= w_on ? (AN_ACTIVE_HIGH ? w_onehot : ~w_onehot) : AN_OFF;
      r_seg <= w_seg;
      r_dp  <= (w_on && w_dp_req && !w_dig_blank) ? ~DP_OFF : DP_OFF;
    end
  end

  assign CC_SEVENSEG_SCAN_an         = r_an;
  assign CC_SEVENSEG_SCAN_seg        = r_seg;
  assign CC_SEVENSEG_SCAN_dp_out     = r_dp;
  assign CC_SEVENSEG_SCAN_pending    = r_pending;
  assign CC_SEVENSEG_SCAN_frame_tick = r_frame_tick;

endmodule
